// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10
    } state_t;

    function automatic logic op_supported(input logic [5:0] op, input logic addi_en);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || (addi_en && op == OP_ADDI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and Funct to ALUControl; flags unsupported Funct codes
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    logic [2:0] fn_ctl;

    // bad_funct ignores alu_op so the controller can flag it during DECODE
    always_comb begin
        fn_ctl    = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            F_ADD:   fn_ctl = ALU_ADD;
            F_SUB:   fn_ctl = ALU_SUB;
            F_AND:   fn_ctl = ALU_AND;
            F_OR:    fn_ctl = ALU_OR;
            F_SLT:   fn_ctl = ALU_SLT;
            default: bad_funct = 1'b1;
        endcase
        alu_control = alu_op == ALUOP_SUB ? ALU_SUB : alu_op == ALUOP_FUNCT ? fn_ctl : ALU_ADD;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter bit ADDI_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               IorD,
    output logic               PCSrc,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal_op
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       bad_funct;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl),
        .bad_funct   (bad_funct)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                                 Opcode == OP_RTYPE ? S_EXECUTE :
                                 Opcode == OP_BEQ ? S_BRANCH :
                                 (ADDI_EN && Opcode == OP_ADDI) ? S_ADDIEX : S_FETCH;
            S_MEMADR:  state_d = Opcode == OP_SW ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        MemToReg = 1'b0;
        RegDst   = 1'b0;
        IorD     = 1'b0;
        PCSrc    = 1'b0;
        ALUSrcA  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcB  = 2'b00;
        alu_op   = ALUOP_ADD;
        case (state_q)
            S_FETCH:    begin ALUSrcB = 2'b01; IRWrite = 1'b1; PCWrite = 1'b1; end
            S_DECODE:   ALUSrcB = 2'b10;
            S_MEMADR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB:    begin MemToReg = 1'b1; RegWrite = 1'b1; end
            S_MEMWRITE: begin IorD = 1'b1; MemWrite = 1'b1; end
            S_EXECUTE:  begin ALUSrcA = 1'b1; alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin RegDst = 1'b1; RegWrite = 1'b1; end
            S_BRANCH:   begin ALUSrcA = 1'b1; alu_op = ALUOP_SUB; PCSrc = 1'b1; Branch = 1'b1; end
            S_ADDIEX:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_ADDIWB:   RegWrite = 1'b1;
            default:    ;
        endcase
        // state already reads FETCH under reset; only its write enables need masking
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Branch   = 1'b0;
        end
        illegal_op = state_q == S_DECODE &&
                     (!op_supported(Opcode, ADDI_EN) || (Opcode == OP_RTYPE && bad_funct));
    end

    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized instruction streams checked against a cycle-level model
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Funct = 6'd0;

    logic       MemToReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite, illegal_op;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    logic       n_MemToReg, n_RegDst, n_IorD, n_PCSrc, n_ALUSrcA, n_IRWrite, n_MemWrite, n_PCWrite, n_Branch, n_RegWrite, n_illegal_op;
    logic [1:0] n_ALUSrcB;
    logic [2:0] n_ALUControl;
    logic [3:0] n_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4), .ADDI_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .MemToReg(MemToReg), .RegDst(RegDst), .IorD(IorD), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .state_o(state_o), .illegal_op(illegal_op)
    );

    multicycle_controller #(.STATE_W(4), .ADDI_EN(1'b0)) dut_na (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .MemToReg(n_MemToReg), .RegDst(n_RegDst), .IorD(n_IorD), .PCSrc(n_PCSrc), .ALUSrcA(n_ALUSrcA),
        .IRWrite(n_IRWrite), .MemWrite(n_MemWrite), .PCWrite(n_PCWrite), .Branch(n_Branch), .RegWrite(n_RegWrite),
        .ALUSrcB(n_ALUSrcB), .ALUControl(n_ALUControl), .state_o(n_state_o), .illegal_op(n_illegal_op)
    );

    logic [14:0] obs;
    logic [4:0]  wen, n_wen;
    assign obs   = {MemToReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUSrcB, ALUControl};
    assign wen   = {IRWrite, PCWrite, MemWrite, RegWrite, Branch};
    assign n_wen = {n_IRWrite, n_PCWrite, n_MemWrite, n_RegWrite, n_Branch};

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
    endfunction

    // expected {MemToReg,RegDst,IorD,PCSrc,ALUSrcA,IRWrite,MemWrite,PCWrite,Branch,RegWrite,ALUSrcB,ALUControl}
    function automatic logic [14:0] exp_out(input int st, input logic [5:0] f);
        logic m2r = 0, rd = 0, iord = 0, pcs = 0, sa = 0, irw = 0, mw = 0, pcw = 0, br = 0, rw = 0;
        logic [1:0] sb = 2'b00;
        logic [2:0] ac = 3'b010;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2'b01; end
            1:  sb = 2'b10;
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; ac = alu_of(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = 3'b110; pcs = 1; br = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            default: ;
        endcase
        return {m2r, rd, iord, pcs, sa, irw, mw, pcw, br, rw, sb, ac};
    endfunction

    // Called during a FETCH cycle; returns during the FETCH cycle of the next instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag);
        int path[$];
        bit ill;
        Opcode = op;
        Funct  = fn;
        ill    = 1'b0;
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: begin path = '{0, 1, 6, 7}; ill = !funct_ok(fn); end
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            default:   begin path = '{0, 1}; ill = 1'b1; end
        endcase
        foreach (path[i]) begin
            @(negedge clk);
            checks++;
            if (state_o !== 4'(path[i])) begin
                errors++;
                $display("FAIL %s state step %0d: got %0d expected %0d", tag, i, state_o, path[i]);
            end
            checks++;
            if (obs !== exp_out(path[i], fn)) begin
                errors++;
                $display("FAIL %s outputs step %0d: got %b expected %b", tag, i, obs, exp_out(path[i], fn));
            end
            checks++;
            if (illegal_op !== (path[i] == 1 && ill)) begin
                errors++;
                $display("FAIL %s illegal_op step %0d: got %b expected %b", tag, i, illegal_op, path[i] == 1 && ill);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Opcode = 6'b100011;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (state_o !== 4'd0 || wen !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold: state %0d wen %b expected state 0 wen 00000", state_o, wen);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(6'b100011, 6'd0, "lw_after_reset");
    endtask

    task automatic test_sw();
        run_instr(6'b101011, 6'b100000, "sw");
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100010, "r_sub");
        run_instr(6'b000000, 6'b101010, "r_slt");
        run_instr(6'b000000, 6'b100100, "r_and");
        run_instr(6'b000000, 6'b100101, "r_or");
        run_instr(6'b000000, 6'b111000, "r_badfunct");
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'b101010, "beq");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b100000, "illegal_op");
        run_instr(6'b001000, 6'b000000, "addi");
    endtask

    task automatic test_addi_disabled();
        Opcode = 6'b001000;
        @(negedge clk);
        checks++;
        if (n_state_o !== 4'd0) begin
            errors++;
            $display("FAIL addi_off fetch: state %0d expected 0", n_state_o);
        end
        @(negedge clk);
        checks++;
        if (n_state_o !== 4'd1 || n_illegal_op !== 1'b1 || n_wen !== 5'b0) begin
            errors++;
            $display("FAIL addi_off decode: state %0d illegal %b wen %b expected 1 1 00000", n_state_o, n_illegal_op, n_wen);
        end
        @(negedge clk);
        checks++;
        if (n_state_o !== 4'd0 || n_illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL addi_off return: state %0d illegal %b expected 0 0", n_state_o, n_illegal_op);
        end
        checks++;
        if (state_o !== 4'd9) begin
            errors++;
            $display("FAIL addi_on exec: state %0d expected 9", state_o);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        Opcode = 6'b000000;
        Funct  = 6'b100000;
        repeat (4) @(negedge clk);
        checks++;
        if (state_o !== 4'd7 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset pre: state %0d RegWrite %b expected 7 1", state_o, RegWrite);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || wen !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset async: state %0d wen %b expected 0 00000", state_o, wen);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || wen !== 5'b0 || obs[1:0] !== 2'b10 || ALUSrcB !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset hold: state %0d wen %b srcb %b expected 0 00000 01", state_o, wen, ALUSrcB);
        end
        reset = 1'b0;
        run_instr(6'b000100, 6'd0, "beq_after_reset");
    endtask

    task automatic test_random();
        logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] ops[5] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000};
        logic [5:0] op, fn;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 6'($urandom); while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000});
            end else begin
                op = ops[$urandom_range(0, 4)];
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
            run_instr(op, fn, "random");
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_rtype();
        test_beq();
        test_illegal();
        test_addi_disabled();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
